// File: rtl/sdram_rd_checker.sv
// Checks an SDRAM read-burst stream against an incrementing pattern (seed, seed+1, ...)
// and reports pass/fail, mismatch count, first mismatch details and idle timeout.
module sdram_rd_checker #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LEN_W       = 9,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] seed,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [LEN_W-1:0]  err_count,
  output logic [LEN_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [DATA_W-1:0] exp_q, exp_nxt;
  logic [LEN_W-1:0]  idx_q, idx_nxt;
  logic [TO_W-1:0]   idle_q, idle_nxt;
  logic              busy_nxt, done_nxt, pass_nxt, timeout_nxt;
  logic [LEN_W-1:0]  err_nxt, fidx_nxt;
  logic [DATA_W-1:0] fexp_nxt, fgot_nxt;

  // State and result registers
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      len_q         <= '0;
      exp_q         <= '0;
      idx_q         <= '0;
      idle_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      state         <= state_nxt;
      len_q         <= len_nxt;
      exp_q         <= exp_nxt;
      idx_q         <= idx_nxt;
      idle_q        <= idle_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      pass          <= pass_nxt;
      timeout       <= timeout_nxt;
      err_count     <= err_nxt;
      first_err_idx <= fidx_nxt;
      first_err_exp <= fexp_nxt;
      first_err_got <= fgot_nxt;
    end
  end

  // Next-state and result computation
  always_comb begin
    state_nxt   = state;
    len_nxt     = len_q;
    exp_nxt     = exp_q;
    idx_nxt     = idx_q;
    idle_nxt    = idle_q;
    pass_nxt    = pass;
    timeout_nxt = timeout;
    err_nxt     = err_count;
    fidx_nxt    = first_err_idx;
    fexp_nxt    = first_err_exp;
    fgot_nxt    = first_err_got;

    case (state)
      S_IDLE: begin
        if (start) begin
          len_nxt     = length;
          exp_nxt     = seed;
          idx_nxt     = '0;
          idle_nxt    = '0;
          err_nxt     = '0;
          fidx_nxt    = '0;
          fexp_nxt    = '0;
          fgot_nxt    = '0;
          timeout_nxt = 1'b0;
          if (length == '0) begin
            state_nxt = S_DONE;
            pass_nxt  = 1'b1;
          end else begin
            state_nxt = S_ARMED;
            pass_nxt  = 1'b0;
          end
        end
      end
      S_ARMED, S_CHECK: begin
        if (rd_ack) begin
          idle_nxt = '0;
          if (rd_data != exp_q) begin
            err_nxt = err_count + LEN_W'(1);
            if (err_count == '0) begin
              fidx_nxt = idx_q;
              fexp_nxt = exp_q;
              fgot_nxt = rd_data;
            end
          end
          exp_nxt = exp_q + DATA_W'(1);
          idx_nxt = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) begin
            state_nxt = S_DONE;
            pass_nxt  = (err_nxt == '0);
          end else begin
            state_nxt = S_CHECK;
          end
        end else begin
          idle_nxt = idle_q + TO_W'(1);
          // Final idle cycle of the allowed window aborts the run
          if (idle_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state_nxt   = S_DONE;
            timeout_nxt = 1'b1;
            pass_nxt    = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt == S_ARMED) || (state_nxt == S_CHECK);
    done_nxt = (state_nxt == S_DONE);
  end

endmodule
